// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: load, shift, rotate, arithmetic shift, clear.
// Saturating shift counter flags a full word shifted (PISO/SIPO use).
module univ_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    cnt,
    output logic             cnt_done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROTL = 3'b100;
    localparam logic [2:0] M_ROTR = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    cnt_inc;

    // Counter stops at FULL; it never wraps back to zero.
    assign cnt_inc = (cnt == FULL) ? FULL : cnt + 1'b1;

    // Next-state decode for data and shift count.
    always_comb begin
        q_nxt   = q;
        cnt_nxt = cnt;
        unique case (mode)
            M_HOLD: begin
                q_nxt   = q;
                cnt_nxt = cnt;
            end
            M_LOAD: begin
                q_nxt   = d;
                cnt_nxt = '0;
            end
            M_SHL: begin
                q_nxt   = {q[WIDTH-2:0], sin_r};
                cnt_nxt = cnt_inc;
            end
            M_SHR: begin
                q_nxt   = {sin_l, q[WIDTH-1:1]};
                cnt_nxt = cnt_inc;
            end
            M_ROTL: begin
                q_nxt   = {q[WIDTH-2:0], q[WIDTH-1]};
                cnt_nxt = cnt_inc;
            end
            M_ROTR: begin
                q_nxt   = {q[0], q[WIDTH-1:1]};
                cnt_nxt = cnt_inc;
            end
            M_ASR: begin
                q_nxt   = {q[WIDTH-1], q[WIDTH-1:1]};
                cnt_nxt = cnt_inc;
            end
            M_CLR: begin
                q_nxt   = '0;
                cnt_nxt = '0;
            end
            default: begin
                q_nxt   = q;
                cnt_nxt = cnt;
            end
        endcase
    end

    // State register: reset beats enable, enable gates every update.
    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= '0;
            cnt      <= '0;
            cnt_done <= 1'b0;
        end else if (en) begin
            q        <= q_nxt;
            cnt      <= cnt_nxt;
            cnt_done <= (cnt_nxt == FULL);
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed table-driven bench for univ_shift_reg at WIDTH=8.
// Hand sequences cover serial-out order and counter saturation.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst, en, sin_l, sin_r;
    logic [2:0] mode;
    logic [7:0] d, q;
    logic       sout_l, sout_r, cnt_done;
    logic [3:0] cnt;

    int n_vec = 0;
    int n_bad = 0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l),
        .sout_r(sout_r), .cnt(cnt), .cnt_done(cnt_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sl;
        logic       sr;
        logic [7:0] eq;
        logic [3:0] ec;
        logic       ed;
    } vec_t;

    vec_t tbl[$];

    task automatic add(string nm, logic r, logic e, logic [2:0] m,
                       logic [7:0] dd, logic sl, logic sr,
                       logic [7:0] eq, logic [3:0] ec, logic ed);
        vec_t v;
        v.name = nm; v.rst = r; v.en = e; v.mode = m; v.d = dd;
        v.sl = sl; v.sr = sr; v.eq = eq; v.ec = ec; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic step(logic r, logic e, logic [2:0] m,
                        logic [7:0] dd, logic sl, logic sr);
        @(negedge clk);
        rst = r; en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [7:0] eq,
                         logic [3:0] ec, logic ed);
        n_vec++;
        if (q !== eq || cnt !== ec || cnt_done !== ed ||
            sout_l !== eq[7] || sout_r !== eq[0]) begin
            n_bad++;
            $display("FAIL %s: q=%h cnt=%0d done=%b sl=%b sr=%b, want q=%h cnt=%0d done=%b",
                     nm, q, cnt, cnt_done, sout_l, sout_r, eq, ec, ed);
        end
    endtask

    logic [7:0] coll;
    logic [7:0] rq;

    initial begin
        rst = 1'b0; en = 1'b0; mode = 3'd0; d = 8'h00;
        sin_l = 1'b0; sin_r = 1'b0;

        add("reset",   1,1,3'd1,8'hFF,0,0, 8'h00,0,0);
        add("load_a5", 0,1,3'd1,8'hA5,1,1, 8'hA5,0,0);
        add("rotl",    0,1,3'd4,8'h00,0,0, 8'h4B,1,0);
        add("rotr",    0,1,3'd5,8'h00,0,0, 8'hA5,2,0);
        add("load_c3", 0,1,3'd1,8'hC3,0,0, 8'hC3,0,0);
        add("shr1",    0,1,3'd3,8'h00,0,1, 8'h61,1,0);
        add("shr2",    0,1,3'd3,8'h00,0,1, 8'h30,2,0);
        add("shr3",    0,1,3'd3,8'h00,0,1, 8'h18,3,0);
        add("shr4",    0,1,3'd3,8'h00,0,1, 8'h0C,4,0);
        add("shr5",    0,1,3'd3,8'h00,0,1, 8'h06,5,0);
        add("shr6",    0,1,3'd3,8'h00,0,1, 8'h03,6,0);
        add("shr7",    0,1,3'd3,8'h00,0,1, 8'h01,7,0);
        add("shr8",    0,1,3'd3,8'h00,0,1, 8'h00,8,1);
        add("shr9sat", 0,1,3'd3,8'h00,0,1, 8'h00,8,1);
        add("clr",     0,1,3'd7,8'h5A,1,1, 8'h00,0,0);
        add("shl1",    0,1,3'd2,8'h00,0,1, 8'h01,1,0);
        add("shl2",    0,1,3'd2,8'h00,1,0, 8'h02,2,0);
        add("shl3",    0,1,3'd2,8'h00,0,1, 8'h05,3,0);
        add("shl4",    0,1,3'd2,8'h00,0,1, 8'h0B,4,0);
        add("shl5",    0,1,3'd2,8'h00,1,0, 8'h16,5,0);
        add("shl6",    0,1,3'd2,8'h00,0,0, 8'h2C,6,0);
        add("shl7",    0,1,3'd2,8'h00,0,1, 8'h59,7,0);
        add("shl8",    0,1,3'd2,8'h00,0,0, 8'hB2,8,1);
        add("asr",     0,1,3'd6,8'h00,0,1, 8'hD9,8,1);
        add("load_3c", 0,1,3'd1,8'h3C,0,0, 8'h3C,0,0);
        for (int i = 0; i < 5; i++)
            add("en_off",  0,0,3'd2,8'h00,1,1, 8'h3C,0,0);
        add("en_offclr",0,0,3'd7,8'h00,0,0, 8'h3C,0,0);
        add("load_ff", 0,1,3'd1,8'hFF,0,0, 8'hFF,0,0);
        add("shl0_1",  0,1,3'd2,8'h00,1,0, 8'hFE,1,0);
        add("shl0_2",  0,1,3'd2,8'h00,1,0, 8'hFC,2,0);
        add("shl0_3",  0,1,3'd2,8'h00,1,0, 8'hF8,3,0);
        add("rst_mid", 1,1,3'd2,8'h00,1,1, 8'h00,0,0);
        add("shl_aft", 0,1,3'd2,8'h00,0,1, 8'h01,1,0);
        add("shr_sl1", 0,1,3'd3,8'h00,1,0, 8'h80,2,0);
        add("rotl_w",  0,1,3'd4,8'h00,0,0, 8'h01,3,0);
        add("asr_pos", 0,1,3'd6,8'h00,1,1, 8'h00,4,0);
        add("hold",    0,1,3'd0,8'hFF,1,1, 8'h00,4,0);
        add("load_55", 0,1,3'd1,8'h55,0,0, 8'h55,0,0);
        add("rst_en0", 1,0,3'd2,8'h00,0,0, 8'h00,0,0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].mode,
                 tbl[i].d, tbl[i].sl, tbl[i].sr);
            check(tbl[i].name, tbl[i].eq, tbl[i].ec, tbl[i].ed);
        end

        // PISO: collect sout_r before each shift edge
        step(0, 1, 3'd1, 8'hC3, 0, 0);
        check("piso_load", 8'hC3, 0, 0);
        coll = 8'h00;
        for (int i = 0; i < 8; i++) begin
            coll[i] = sout_r;
            step(0, 1, 3'd3, 8'h00, 0, 0);
            if (i == 6) check("piso_7th", 8'h01, 7, 0);
        end
        check("piso_end", 8'h00, 8, 1);
        n_vec++;
        if (coll !== 8'b1100_0011) begin
            n_bad++;
            $display("FAIL piso_bits: got %b want %b", coll, 8'b1100_0011);
        end

        // Counter saturation under continued rotation
        step(0, 1, 3'd1, 8'hA5, 0, 0);
        rq = 8'hA5;
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 3'd5, 8'h00, 0, 0);
            rq = {rq[0], rq[7:1]};
            check("rotr_sat", rq, (i >= 8) ? 4'd8 : 4'(i), i >= 8);
        end
        check("rotr_final", 8'h5A, 8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
